// File: rtl/line_path_sequencer.sv
// line_path_sequencer: drives endpoint pairs and a one-cycle set strobe into
// a line drawer. After an INIT line it runs a four-phase expand/collapse sweep
// between X_MIN and X_MAX. Each advance waits for the hold timer to saturate
// and for the drawer to be ready.
// Optional build macro: LINE_PATH_ERASE_EN. When it is defined, each advance
// first redraws the old line with colour=0 and then draws the new line with
// colour=1.
module line_path_sequencer #(
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int X_MIN       = 20,
  parameter int X_MAX       = 620,
  parameter int Y_TOP       = 20,
  parameter int Y_BOT       = 460,
  parameter int STEP        = 120,
  parameter int HOLD_CYCLES = 50000000,
  parameter int FRAME_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic               drawer_ready,
  output logic [X_W-1:0]     x0,
  output logic [X_W-1:0]     x1,
  output logic [Y_W-1:0]     y0,
  output logic [Y_W-1:0]     y1,
  output logic               set,
  output logic               busy,
  output logic [2:0]         phase,
  output logic [FRAME_W-1:0] frame_count,
  output logic               colour
);

  localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [X_W-1:0] X_MIN_V = X_W'(X_MIN);
  localparam logic [X_W-1:0] X_MAX_V = X_W'(X_MAX);

  generate
    if (STEP <= 0) begin : g_bad_step
      $error("line_path_sequencer: STEP must be greater than zero");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("line_path_sequencer: HOLD_CYCLES must be at least one");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_RUN0 = 3'd2,
    S_RUN1 = 3'd3,
    S_RUN2 = 3'd4,
    S_RUN3 = 3'd5
  } state_t;

  state_t             state_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [TIMER_W-1:0] timer_inc;
  logic [X_W-1:0]     x0_adv;
  logic [X_W-1:0]     x1_adv;
  logic               exit_now;
  logic               exit_go;
  logic               advance;

  // The sum uses one extra bit so that it cannot wrap before it is clamped to X_MAX.
  function automatic logic [X_W-1:0] step_up(input logic [X_W-1:0] x);
    logic [X_W:0] sum;
    sum = {1'b0, x} + (X_W+1)'(STEP);
    if (sum > (X_W+1)'(X_MAX)) return X_MAX_V;
    return sum[X_W-1:0];
  endfunction

  // The lower bound is checked before subtracting, so the result never underflows.
  function automatic logic [X_W-1:0] step_dn(input logic [X_W-1:0] x);
    if (int'({1'b0, x}) < X_MIN + STEP) return X_MIN_V;
    return x - X_W'(STEP);
  endfunction

  assign timer_inc = (timer_reg == HOLD_LAST) ? timer_reg : timer_reg + TIMER_W'(1);
  assign advance   = (timer_reg == HOLD_LAST) && drawer_ready;
  assign busy      = (state_reg != S_IDLE);
  assign phase     = state_reg;

  // Select the coordinate each phase moves. The phase exit is tested on the value already visible.
  always_comb begin
    x0_adv   = x0;
    x1_adv   = x1;
    exit_now = 1'b0;
    case (state_reg)
      S_RUN0: begin x1_adv = step_up(x1); exit_now = (x1 == X_MAX_V); end
      S_RUN1: begin x0_adv = step_up(x0); exit_now = (x0 == X_MAX_V); end
      S_RUN2: begin x1_adv = step_dn(x1); exit_now = (x1 == X_MIN_V); end
      S_RUN3: begin x0_adv = step_dn(x0); exit_now = (x0 == X_MIN_V); end
      default: ;
    endcase
  end

`ifdef LINE_PATH_ERASE_EN
  logic erase_pending_reg;
  assign exit_go = exit_now && !erase_pending_reg;
`else
  assign exit_go = exit_now;
`endif

  // Sequencer state, hold timer and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      timer_reg   <= '0;
      x0          <= '0;
      x1          <= '0;
      y0          <= '0;
      y1          <= '0;
      set         <= 1'b0;
      frame_count <= '0;
      colour      <= 1'b1;
`ifdef LINE_PATH_ERASE_EN
      erase_pending_reg <= 1'b0;
`endif
    end else begin
      set <= 1'b0;
      if (state_reg == S_IDLE) begin
        if (start && !stop) begin
          state_reg <= S_INIT;
          x0        <= X_MIN_V;
          x1        <= X_MIN_V;
          y0        <= Y_W'(Y_TOP);
          y1        <= Y_W'(Y_BOT);
          set       <= 1'b1;
          colour    <= 1'b1;
          timer_reg <= '0;
        end
      end else if (stop) begin
        state_reg <= S_IDLE;
        colour    <= 1'b1;
`ifdef LINE_PATH_ERASE_EN
        erase_pending_reg <= 1'b0;
`endif
      end else if (state_reg == S_INIT) begin
        state_reg <= S_RUN0;
        timer_reg <= timer_inc;
      end else begin
        timer_reg <= timer_inc;
        if (exit_go) begin
          case (state_reg)
            S_RUN0: state_reg <= S_RUN1;
            S_RUN1: state_reg <= S_RUN2;
            S_RUN2: state_reg <= S_RUN3;
            default: begin
              frame_count <= frame_count + FRAME_W'(1);
              state_reg   <= loop ? S_RUN0 : S_IDLE;
            end
          endcase
`ifdef LINE_PATH_ERASE_EN
        end else if (!erase_pending_reg) begin
          if (advance) begin
            set               <= 1'b1;
            colour            <= 1'b0;
            erase_pending_reg <= 1'b1;
          end
        end else if (!set && drawer_ready) begin
          set               <= 1'b1;
          colour            <= 1'b1;
          erase_pending_reg <= 1'b0;
          timer_reg         <= '0;
          x0                <= x0_adv;
          x1                <= x1_adv;
        end
`else
        end else if (advance) begin
          set       <= 1'b1;
          timer_reg <= '0;
          x0        <= x0_adv;
          x1        <= x1_adv;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_line_path_sequencer.sv
// Scoreboard bench for line_path_sequencer. Two instances are used: the
// default STEP=120 and STEP=250. Both have HOLD_CYCLES=4.
module tb_line_path_sequencer;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [8:0] y0;
    logic [8:0] y1;
    logic       colour;
    logic [2:0] phase;
  } txn_t;

  logic       clk, reset, drawer_ready;
  logic       start_a, stop_a, loop_a, start_b, stop_b, loop_b;
  logic [9:0] x0_a, x1_a, x0_b, x1_b;
  logic [8:0] y0_a, y1_a, y0_b, y1_b;
  logic       set_a, busy_a, colour_a, set_b, busy_b, colour_b;
  logic [2:0] phase_a, phase_b;
  logic [7:0] fc_a, fc_b;

  txn_t qa[$];
  txn_t qb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  bit   have_last = 0;
  bit   gap_on = 0;

  line_path_sequencer #(.HOLD_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .loop(loop_a),
    .drawer_ready(drawer_ready), .x0(x0_a), .x1(x1_a), .y0(y0_a), .y1(y1_a),
    .set(set_a), .busy(busy_a), .phase(phase_a), .frame_count(fc_a), .colour(colour_a)
  );

  line_path_sequencer #(.HOLD_CYCLES(4), .STEP(250)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .loop(loop_b),
    .drawer_ready(drawer_ready), .x0(x0_b), .x1(x1_b), .y0(y0_b), .y1(y1_b),
    .set(set_b), .busy(busy_b), .phase(phase_b), .frame_count(fc_b), .colour(colour_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_txn(input bit to_b, input txn_t t);
    if (to_b) qb.push_back(t);
    else qa.push_back(t);
  endtask

  // One advance. In the erase build the old line comes first with colour 0.
  task automatic push_adv(input bit to_b, input int ph, input int ox0, input int ox1,
                          input int nx0, input int nx1);
    txn_t t;
`ifdef LINE_PATH_ERASE_EN
    t = '{x0: 10'(ox0), x1: 10'(ox1), y0: 9'd20, y1: 9'd460, colour: 1'b0, phase: 3'(ph)};
    push_txn(to_b, t);
`endif
    t = '{x0: 10'(nx0), x1: 10'(nx1), y0: 9'd20, y1: 9'd460, colour: 1'b1, phase: 3'(ph)};
    push_txn(to_b, t);
  endtask

  // Hand-computed frame. The first n_adv advances are pushed, with an optional INIT line first.
  task automatic push_frame(input bit to_b, input bit with_init, input int n_adv);
    int up[$];
    int dn[$];
    int cx0, cx1, n;
    txn_t t;
    if (to_b) begin up = '{270, 520, 620}; dn = '{370, 120, 20}; end
    else begin up = '{140, 260, 380, 500, 620}; dn = '{500, 380, 260, 140, 20}; end
    cx0 = 20; cx1 = 20; n = 0;
    if (with_init) begin
      t = '{x0: 10'd20, x1: 10'd20, y0: 9'd20, y1: 9'd460, colour: 1'b1, phase: 3'd1};
      push_txn(to_b, t);
    end
    foreach (up[i]) if (n < n_adv) begin push_adv(to_b, 2, cx0, cx1, cx0, up[i]); cx1 = up[i]; n++; end
    foreach (up[i]) if (n < n_adv) begin push_adv(to_b, 3, cx0, cx1, up[i], cx1); cx0 = up[i]; n++; end
    foreach (dn[i]) if (n < n_adv) begin push_adv(to_b, 4, cx0, cx1, cx0, dn[i]); cx1 = dn[i]; n++; end
    foreach (dn[i]) if (n < n_adv) begin push_adv(to_b, 5, cx0, cx1, dn[i], cx1); cx0 = dn[i]; n++; end
  endtask

  task automatic wait_idle(input bit to_b, input string name, input int limit);
    int n = 0;
    while ((to_b ? busy_b : busy_a) && n < limit) begin @(negedge clk); n++; end
    check(name, (n < limit) ? 1 : 0, 1);
  endtask

  // Monitor for instance A: pops the next expected line whenever set is high.
  always @(negedge clk) begin
    txn_t e;
    if (!gap_on) have_last = 0;
    if (reset && set_a) begin
      if (gap_on && have_last) check("a_set_gap", cyc - last_cyc, 4);
      last_cyc  = cyc;
      have_last = 1;
      if (qa.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL a_unexpected_set actual=x0 %0d x1 %0d phase %0d required=no set",
                 x0_a, x1_a, phase_a);
      end else begin
        e = qa.pop_front();
        check("a_x0", int'(x0_a), int'(e.x0));
        check("a_x1", int'(x1_a), int'(e.x1));
        check("a_y0", int'(y0_a), int'(e.y0));
        check("a_y1", int'(y1_a), int'(e.y1));
        check("a_colour", int'(colour_a), int'(e.colour));
        check("a_phase", int'(phase_a), int'(e.phase));
      end
    end
  end

  // Monitor for instance B: pops the next expected line whenever set is high.
  always @(negedge clk) begin
    txn_t e;
    if (reset && set_b) begin
      if (qb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL b_unexpected_set actual=x0 %0d x1 %0d required=no set", x0_b, x1_b);
      end else begin
        e = qb.pop_front();
        check("b_x0", int'(x0_b), int'(e.x0));
        check("b_x1", int'(x1_b), int'(e.x1));
        check("b_colour", int'(colour_b), int'(e.colour));
        check("b_phase", int'(phase_b), int'(e.phase));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int sets;
    reset = 1'b0; drawer_ready = 1'b1;
    start_a = 0; stop_a = 0; loop_a = 0; start_b = 0; stop_b = 0; loop_b = 0;
    repeat (3) @(negedge clk);
    check("rst_x0", x0_a, 0);   check("rst_x1", x1_a, 0);
    check("rst_y0", y0_a, 0);   check("rst_y1", y1_a, 0);
    check("rst_set", set_a, 0); check("rst_busy", busy_a, 0);
    check("rst_phase", phase_a, 0); check("rst_fc", fc_a, 0);
    check("rst_colour", colour_a, 1);
    reset = 1'b1;
    @(negedge clk);

    // Single frame, drawer always ready.
    push_frame(0, 1, 20);
`ifndef LINE_PATH_ERASE_EN
    gap_on = 1;
`endif
    start_a = 1; @(negedge clk); start_a = 0;
    check("t1_busy_init", busy_a, 1); check("t1_phase_init", phase_a, 1);
    wait_idle(0, "t1_idle_timeout", 1000);
    gap_on = 0;
    check("t1_queue_left", qa.size(), 0); check("t1_fc", fc_a, 1); check("t1_phase_idle", phase_a, 0);

    // Drawer stalls for 10 cycles in RUN1. A start pulse while busy must be ignored.
    push_frame(0, 1, 20);
    start_a = 1; @(negedge clk); start_a = 0;
    n = 0;
    while (!(set_a && x0_a == 10'd260 && phase_a == 3'd3 && colour_a) && n < 1000) begin
      @(negedge clk); n++;
    end
    check("t2_reach_timeout", (n < 1000) ? 1 : 0, 1);
    drawer_ready = 0; sets = 0;
    repeat (10) begin @(negedge clk); if (set_a) sets++; end
    check("t2_stall_sets", sets, 0); check("t2_stall_x0", x0_a, 260);
    drawer_ready = 1; @(negedge clk);
    check("t2_resume_set", set_a, 1);
`ifdef LINE_PATH_ERASE_EN
    check("t2_resume_x0", x0_a, 260);
`else
    check("t2_resume_x0", x0_a, 380);
`endif
    start_a = 1; @(negedge clk); start_a = 0;
    wait_idle(0, "t2_idle_timeout", 1000);
    check("t2_queue_left", qa.size(), 0); check("t2_fc", fc_a, 2);

    // Loop mode over two frames, then stop.
    push_frame(0, 1, 20); push_frame(0, 0, 20);
    loop_a = 1; start_a = 1; @(negedge clk); start_a = 0;
    n = 0;
    while (fc_a != 8'd3 && n < 1000) begin @(negedge clk); n++; end
    check("t3_fc3_timeout", (n < 1000) ? 1 : 0, 1);
    check("t3_busy_wrap", busy_a, 1); check("t3_phase_wrap", phase_a, 2);
    n = 0;
    while (fc_a != 8'd4 && n < 1000) begin @(negedge clk); n++; end
    check("t3_fc4_timeout", (n < 1000) ? 1 : 0, 1);
    stop_a = 1; loop_a = 0; @(negedge clk); stop_a = 0;
    check("t3_busy_stop", busy_a, 0); check("t3_queue_left", qa.size(), 0); check("t3_fc", fc_a, 4);

    // Stop at x1=380 in RUN0.
    push_frame(0, 1, 3);
    start_a = 1; @(negedge clk); start_a = 0;
    n = 0;
    while (!(set_a && x1_a == 10'd380 && phase_a == 3'd2 && colour_a) && n < 1000) begin
      @(negedge clk); n++;
    end
    check("t4_reach_timeout", (n < 1000) ? 1 : 0, 1);
    stop_a = 1; @(negedge clk); stop_a = 0;
    check("t4_busy", busy_a, 0); check("t4_phase", phase_a, 0);
    sets = 0;
    repeat (10) begin @(negedge clk); if (set_a) sets++; end
    check("t4_no_set", sets, 0); check("t4_x1_held", x1_a, 380);
    check("t4_fc", fc_a, 4); check("t4_queue_left", qa.size(), 0);

    // Restart from INIT, then apply an asynchronous reset in RUN2.
    push_frame(0, 1, 12);
    start_a = 1; @(negedge clk); start_a = 0;
    n = 0;
    while (!(set_a && x1_a == 10'd380 && phase_a == 3'd4 && colour_a) && n < 1000) begin
      @(negedge clk); n++;
    end
    check("t5_reach_timeout", (n < 1000) ? 1 : 0, 1);
    @(posedge clk); #3; reset = 0; #1;
    check("t5_x0", x0_a, 0); check("t5_x1", x1_a, 0);
    check("t5_y0", y0_a, 0); check("t5_y1", y1_a, 0);
    check("t5_set", set_a, 0); check("t5_busy", busy_a, 0);
    check("t5_phase", phase_a, 0); check("t5_fc", fc_a, 0);
    check("t5_colour", colour_a, 1); check("t5_queue_left", qa.size(), 0);
    @(negedge clk); reset = 1; @(negedge clk);

    // STEP=250: the last step clamps at 620 and the return clamps at 20.
    push_frame(1, 1, 12);
    start_b = 1; @(negedge clk); start_b = 0;
    check("t6_busy", busy_b, 1);
    wait_idle(1, "t6_idle_timeout", 1000);
    check("t6_queue_left", qb.size(), 0); check("t6_fc", fc_b, 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
